// File: rtl/core_bp_pkg.sv
// core_bp_pkg: shared types, constants and helpers for the IF-stage branch predictor.
package core_bp_pkg;

  // BTB entry type encoding, as written back by decode
  localparam logic [1:0] BTB_BR  = 2'b00;
  localparam logic [1:0] BTB_J   = 2'b01;
  localparam logic [1:0] BTB_JAL = 2'b10;
  localparam logic [1:0] BTB_JR  = 2'b11;

  localparam int BHR_W = 3;

  // Weakly-not-taken start point for every PHT counter
  localparam logic [1:0] PHT_INIT = 2'b01;

  typedef logic [1:0]       btb_type_t;
  typedef logic [1:0]       pht_ctr_t;
  typedef logic [BHR_W-1:0] bhr_t;

  // Everything the decode stage needs to know about how this fetch was predicted
  typedef struct packed {
    logic        hit;
    btb_type_t   btype;
    logic [31:0] target;
    pht_ctr_t    ctr;
    bhr_t        bhr;
  } bp_info_t;

  // 2-bit saturating counter step: count up on taken, down on not-taken, clamp at 00/11
  function automatic pht_ctr_t sat_update(input pht_ctr_t ctr, input logic taken);
    pht_ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/core_if_bp_if.sv
// core_if_bp_if: fetch, prediction and decode-feedback signals of the IF-stage predictor.
// master = pipeline side driving fetch/update, slave = the predictor itself.
interface core_if_bp_if;
  import core_bp_pkg::*;

  // fetch side
  logic [31:0] fetch_pc;
  logic        stall;
  logic        flush;
  logic        pred_taken;
  logic [31:0] pred_pc;

  // prediction info aligned with the IF/ID instruction
  logic        btb_v;
  btb_type_t   btb_type;
  logic [31:0] pred_target;
  pht_ctr_t    delayed_PHT;
  bhr_t        delayed_BHR;

  // training / repair stream from decode
  logic [31:0] id_plus_4;
  logic        update_btb_target_in;
  logic [31:0] btb_target_in;
  btb_type_t   btb_type_in;
  logic        update_BP_in;
  logic        taken_in;
  pht_ctr_t    delayed_PHT_in;
  bhr_t        delayed_BHR_in;
  logic        recover_push;
  logic [31:0] recover_push_addr;
  logic        recover_pop;

  modport master (
    output fetch_pc, stall, flush,
    output id_plus_4, update_btb_target_in, btb_target_in, btb_type_in,
    output update_BP_in, taken_in, delayed_PHT_in, delayed_BHR_in,
    output recover_push, recover_push_addr, recover_pop,
    input  pred_taken, pred_pc, btb_v, btb_type, pred_target, delayed_PHT, delayed_BHR
  );

  modport slave (
    input  fetch_pc, stall, flush,
    input  id_plus_4, update_btb_target_in, btb_target_in, btb_type_in,
    input  update_BP_in, taken_in, delayed_PHT_in, delayed_BHR_in,
    input  recover_push, recover_push_addr, recover_pop,
    output pred_taken, pred_pc, btb_v, btb_type, pred_target, delayed_PHT, delayed_BHR
  );

endinterface

// File: rtl/core_if_ras.sv
// core_if_ras: circular return-address stack with decode-driven repair.
// Only compiled when CORE_BP_RAS_EN is defined. Repair op (recover push/pop) is applied
// before the fetch op of the same cycle; overflow overwrites the oldest entry and underflow
// simply wraps the pointer, leaving a stale top.
`ifdef CORE_BP_RAS_EN
module core_if_ras
  import core_bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [31:0] push_addr_i,
  input  logic        pop_i,
  input  logic        rec_push_i,
  input  logic [31:0] rec_addr_i,
  input  logic        rec_pop_i,
  output logic [31:0] top_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;
  logic [PW-1:0]    mid_ptr;
  logic [PW-1:0]    top_ptr;
  logic [31:0]      ent_q [DEPTH];
  logic [DEPTH-1:0] rec_we;
  logic [DEPTH-1:0] fetch_we;

  // pointer after the repair op, then after the fetch op; recover_pop loses to recover_push
  always_comb begin
    mid_ptr = ptr_q;
    if (rec_push_i)     mid_ptr = ptr_q + PW'(1);
    else if (rec_pop_i) mid_ptr = ptr_q - PW'(1);
    ptr_d = mid_ptr;
    if (push_i)         ptr_d = mid_ptr + PW'(1);
    else if (pop_i)     ptr_d = mid_ptr - PW'(1);
  end

  // per-slot write enables: repair writes at the current pointer, fetch at the post-repair one
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign rec_we[gi]   = rec_push_i && (ptr_q == PW'(gi));
    assign fetch_we[gi] = push_i && (mid_ptr == PW'(gi));
  end

  // stack pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // stack storage; both writes can land in one cycle on different slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fetch_we[i])    ent_q[i] <= push_addr_i;
        else if (rec_we[i]) ent_q[i] <= rec_addr_i;
      end
    end
  end

  assign top_ptr = ptr_q - PW'(1);
  assign top_o   = ent_q[top_ptr];

endmodule
`endif

// File: rtl/core_if_bp.sv
// core_if_bp: IF-stage branch predictor -- direct-mapped BTB, gshare PHT of 2-bit counters,
// 3-bit global history and (optionally) a return-address stack.
// Build option: define CORE_BP_RAS_EN to include the RAS; otherwise jr predicts the BTB
// target and the recover inputs are ignored.
module core_if_bp
  import core_bp_pkg::*;
#(
  parameter int BTB_AW    = 4,
  parameter int PHT_AW    = 6,
  parameter int RAS_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  core_if_bp_if.slave bp
);

  localparam int BTB_N = 1 << BTB_AW;
  localparam int PHT_N = 1 << PHT_AW;
  localparam int TAG_W = 32 - BTB_AW - 2;

  // predictor state
  logic [BTB_N-1:0] btb_valid_q;
  logic [TAG_W-1:0] btb_tag_q  [BTB_N];
  logic [31:0]      btb_tgt_q  [BTB_N];
  btb_type_t        btb_type_q [BTB_N];
  pht_ctr_t         pht_q      [PHT_N];
  bhr_t             bhr_q;
  bp_info_t         info_q;
  bp_info_t         info_d;

  // fetch-side lookup
  logic [BTB_AW-1:0] f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic [PHT_AW-1:0] f_pidx;
  logic              f_hit;
  btb_type_t         f_type;
  pht_ctr_t          f_ctr;
  logic [31:0]       f_target;
  logic              f_taken;

  // decode-side update
  logic [31:0]       u_pc;
  logic [BTB_AW-1:0] u_idx;
  logic [PHT_AW-1:0] u_pidx;
  pht_ctr_t          pht_new;
  logic [PHT_N-1:0]  pht_we;

  assign f_idx  = bp.fetch_pc[BTB_AW+1:2];
  assign f_tag  = bp.fetch_pc[31:BTB_AW+2];
  assign f_pidx = bp.fetch_pc[PHT_AW+1:2] ^ {{(PHT_AW-BHR_W){1'b0}}, bhr_q};
  assign f_hit  = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
  assign f_type = btb_type_q[f_idx];
  assign f_ctr  = pht_q[f_pidx];

`ifdef CORE_BP_RAS_EN
  logic [31:0] ras_top;
  logic        ras_push;
  logic        ras_pop;

  // fetch-side stack ops only for an instruction that actually advances into IF/ID
  assign ras_push = !bp.stall && !bp.flush && f_hit && (f_type == BTB_JAL);
  assign ras_pop  = !bp.stall && !bp.flush && f_hit && (f_type == BTB_JR);

  core_if_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (ras_push),
    .push_addr_i(bp.fetch_pc + 32'd4),
    .pop_i      (ras_pop),
    .rec_push_i (bp.recover_push),
    .rec_addr_i (bp.recover_push_addr),
    .rec_pop_i  (bp.recover_pop),
    .top_o      (ras_top)
  );

  assign f_target = (f_type == BTB_JR) ? ras_top : btb_tgt_q[f_idx];
`else
  logic [31:0] unused_ras;

  // without a RAS the repair stream has nothing to act on
  assign unused_ras = bp.recover_push_addr ^ 32'(RAS_DEPTH)
                    ^ {30'd0, bp.recover_push, bp.recover_pop};
  assign f_target   = btb_tgt_q[f_idx];
`endif

  // conditional branches follow the PHT; every other hit type always redirects
  assign f_taken       = f_hit && ((f_type != BTB_BR) || f_ctr[1]);
  assign bp.pred_taken = f_taken;
  assign bp.pred_pc    = f_taken ? f_target : (bp.fetch_pc + 32'd4);

  // IF/ID alignment: flush clears (wins over stall), stall holds, otherwise capture lookup
  always_comb begin
    info_d = info_q;
    if (bp.flush) begin
      info_d = '0;
    end else if (!bp.stall) begin
      info_d.hit    = f_hit;
      info_d.btype  = f_hit ? f_type : BTB_BR;
      info_d.target = f_hit ? f_target : 32'd0;
      info_d.ctr    = f_ctr;
      info_d.bhr    = bhr_q;
    end
  end

  // alignment register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) info_q <= '0;
    else     info_q <= info_d;
  end

  assign bp.btb_v       = info_q.hit;
  assign bp.btb_type    = info_q.btype;
  assign bp.pred_target = info_q.target;
  assign bp.delayed_PHT = info_q.ctr;
  assign bp.delayed_BHR = info_q.bhr;

  // decode hands back PC+4; the trained instruction sits one word below it
  assign u_pc    = bp.id_plus_4 - 32'd4;
  assign u_idx   = u_pc[BTB_AW+1:2];
  assign u_pidx  = u_pc[PHT_AW+1:2] ^ {{(PHT_AW-BHR_W){1'b0}}, bp.delayed_BHR_in};
  assign pht_new = sat_update(bp.delayed_PHT_in, bp.taken_in);

  logic [1:0] unused_upc_lsb;
  assign unused_upc_lsb = u_pc[1:0];

  for (genvar gi = 0; gi < PHT_N; gi++) begin : g_pht_we
    assign pht_we[gi] = bp.update_BP_in && (u_pidx == PHT_AW'(gi));
  end

  // BTB valid bits; a write becomes visible to lookup on the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           btb_valid_q <= '0;
    else if (bp.update_btb_target_in)  btb_valid_q[u_idx] <= 1'b1;
  end

  // BTB payload, qualified by the valid bits so it needs no reset
  always_ff @(posedge clk) begin
    if (bp.update_btb_target_in) begin
      btb_tag_q[u_idx]  <= u_pc[31:BTB_AW+2];
      btb_tgt_q[u_idx]  <= bp.btb_target_in;
      btb_type_q[u_idx] <= bp.btb_type_in;
    end
  end

  // PHT training from the counter value decode carried along with the instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= PHT_INIT;
    end else begin
      for (int i = 0; i < PHT_N; i++) begin
        if (pht_we[i]) pht_q[i] <= pht_new;
      end
    end
  end

  // global history advances only on resolved outcomes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  bhr_q <= '0;
    else if (bp.update_BP_in) bhr_q <= {bhr_q[BHR_W-2:0], bp.taken_in};
  end

endmodule

// File: tb/tb_core_if_bp.sv
// tb_core_if_bp: directed scenarios plus randomized traffic for core_if_bp, checked every
// cycle against a behavioural predictor model. Define CORE_BP_RAS_EN to match the RTL build.
module tb_core_if_bp;
  import core_bp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_if_bp_if bp_if ();

  core_if_bp dut (
    .clk(clk),
    .rst(rst),
    .bp (bp_if)
  );

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_typ [16];
  int          m_pht [64];
  int          m_bhr;
  int          m_btb_v, m_btb_type, m_dpht, m_dbhr;
  logic [31:0] m_ptarget;
`ifdef CORE_BP_RAS_EN
  logic [31:0] m_ras [4];
  int          m_sp;

  function automatic int slot(input int s);
    return ((s % 4) + 4) % 4;
  endfunction

  task automatic ras_push(input logic [31:0] a);
    m_ras[slot(m_sp)] = a;
    m_sp++;
  endtask
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_typ[i] = 0; end
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_bhr = 0;
    m_btb_v = 0; m_btb_type = 0; m_dpht = 0; m_dbhr = 0; m_ptarget = 0;
`ifdef CORE_BP_RAS_EN
    for (int i = 0; i < 4; i++) m_ras[i] = 0;
    m_sp = 0;
`endif
  endtask

  task automatic idle_inputs();
    bp_if.stall = 0; bp_if.flush = 0;
    bp_if.id_plus_4 = 0; bp_if.update_btb_target_in = 0; bp_if.btb_target_in = 0;
    bp_if.btb_type_in = 0; bp_if.update_BP_in = 0; bp_if.taken_in = 0;
    bp_if.delayed_PHT_in = 0; bp_if.delayed_BHR_in = 0;
    bp_if.recover_push = 0; bp_if.recover_push_addr = 0; bp_if.recover_pop = 0;
  endtask

  // what the predictor should say for the current fetch, from the model tables
  task automatic predict(output bit hit, output int typ, output int ctr,
                         output logic [31:0] tgt, output bit taken, output logic [31:0] npc);
    logic [31:0] pc;
    int i;
    pc  = bp_if.fetch_pc;
    i   = int'((pc >> 2) % 16);
    hit = m_v[i] && (m_tag[i] == (pc >> 6));
    typ = m_typ[i];
    ctr = m_pht[int'((pc >> 2) % 64) ^ m_bhr];
    tgt = m_tgt[i];
`ifdef CORE_BP_RAS_EN
    if (typ == 3) tgt = m_ras[slot(m_sp - 1)];
`endif
    taken = hit && (typ != 0 || ctr >= 2);
    npc   = taken ? tgt : pc + 32'd4;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // compare everything against the model, advance the model, then cross the clock edge
  task automatic tick();
    bit hit, taken;
    int typ, ctr, c, pidx;
    logic [31:0] tgt, npc, upc;
    predict(hit, typ, ctr, tgt, taken, npc);
    check("pred_taken", 32'(bp_if.pred_taken), 32'(taken));
    check("pred_pc", bp_if.pred_pc, npc);
    check("btb_v", 32'(bp_if.btb_v), 32'(m_btb_v));
    if (m_btb_v != 0) begin
      check("btb_type", 32'(bp_if.btb_type), 32'(m_btb_type));
      check("pred_target", bp_if.pred_target, m_ptarget);
    end
    check("delayed_PHT", 32'(bp_if.delayed_PHT), 32'(m_dpht));
    check("delayed_BHR", 32'(bp_if.delayed_BHR), 32'(m_dbhr));

    if (bp_if.flush) begin
      m_btb_v = 0; m_btb_type = 0; m_ptarget = 0; m_dpht = 0; m_dbhr = 0;
    end else if (!bp_if.stall) begin
      m_btb_v = int'(hit); m_btb_type = hit ? typ : 0; m_ptarget = hit ? tgt : 32'd0;
      m_dpht = ctr; m_dbhr = m_bhr;
    end
`ifdef CORE_BP_RAS_EN
    if (bp_if.recover_push)     ras_push(bp_if.recover_push_addr);
    else if (bp_if.recover_pop) m_sp--;
    if (!bp_if.stall && !bp_if.flush && hit) begin
      if (typ == 2)      ras_push(bp_if.fetch_pc + 32'd4);
      else if (typ == 3) m_sp--;
    end
`endif
    upc = bp_if.id_plus_4 - 32'd4;
    if (bp_if.update_btb_target_in) begin
      m_v  [int'((upc >> 2) % 16)] = 1;
      m_tag[int'((upc >> 2) % 16)] = upc >> 6;
      m_tgt[int'((upc >> 2) % 16)] = bp_if.btb_target_in;
      m_typ[int'((upc >> 2) % 16)] = int'(bp_if.btb_type_in);
    end
    if (bp_if.update_BP_in) begin
      pidx = int'((upc >> 2) % 64) ^ int'(bp_if.delayed_BHR_in);
      c = int'(bp_if.delayed_PHT_in) + (bp_if.taken_in ? 1 : -1);
      if (c < 0) c = 0;
      if (c > 3) c = 3;
      m_pht[pidx] = c;
      m_bhr = ((m_bhr << 1) | int'(bp_if.taken_in)) & 7;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic write_btb(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ);
    idle_inputs();
    bp_if.fetch_pc = 32'h108;
    bp_if.id_plus_4 = pc + 32'd4;
    bp_if.update_btb_target_in = 1;
    bp_if.btb_target_in = tgt;
    bp_if.btb_type_in = typ;
    cyc();
    idle_inputs();
    $display("btb write pc=0x%08h tgt=0x%08h type=%0d", pc, tgt, typ);
  endtask

  task automatic train(input logic [31:0] pc, input logic [2:0] bhr_in,
                       input logic [1:0] pht_in, input logic tk);
    idle_inputs();
    bp_if.fetch_pc = 32'h108;
    bp_if.id_plus_4 = pc + 32'd4;
    bp_if.update_BP_in = 1;
    bp_if.delayed_BHR_in = bhr_in;
    bp_if.delayed_PHT_in = pht_in;
    bp_if.taken_in = tk;
    cyc();
    idle_inputs();
    $display("train pc=0x%08h bhr_in=%0d pht_in=%0d taken=%0d", pc, bhr_in, pht_in, tk);
  endtask

  initial begin
    logic [31:0] pc_set;
    idle_inputs();
    bp_if.fetch_pc = 32'h100;
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // reset state and first lookup
    settle();
    check("rst_btb_v", 32'(bp_if.btb_v), 32'd0);
    check("rst_dPHT", 32'(bp_if.delayed_PHT), 32'd0);
    check("rst_pred_taken", 32'(bp_if.pred_taken), 32'd0);
    check("rst_pred_pc", bp_if.pred_pc, 32'h104);
    tick();
    bp_if.fetch_pc = 32'h108;
    settle();
    check("first_btb_v", 32'(bp_if.btb_v), 32'd0);
    check("first_dPHT", 32'(bp_if.delayed_PHT), 32'd1);
    tick();
    $display("reset lookup done");

    // conditional branch learnt taken
    write_btb(32'h100, 32'h200, BTB_BR);
    train(32'h100, 3'd3, 2'b01, 1'b1);
    train(32'h100, 3'd3, 2'b10, 1'b1);
    bp_if.fetch_pc = 32'h100;
    settle();
    check("br_taken", 32'(bp_if.pred_taken), 32'd1);
    check("br_pred_pc", bp_if.pred_pc, 32'h200);
    tick();
    bp_if.fetch_pc = 32'h108;
    settle();
    check("br_btb_v", 32'(bp_if.btb_v), 32'd1);
    check("br_dPHT", 32'(bp_if.delayed_PHT), 32'd3);
    check("br_dBHR", 32'(bp_if.delayed_BHR), 32'd3);
    check("br_target", bp_if.pred_target, 32'h200);
    tick();

    // saturation at 00 and BHR 011 -> 110
    train(32'h100, 3'd6, 2'b00, 1'b0);
    bp_if.fetch_pc = 32'h100;
    settle();
    check("sat00_taken", 32'(bp_if.pred_taken), 32'd0);
    tick();
    bp_if.fetch_pc = 32'h108;
    settle();
    check("sat00_dPHT", 32'(bp_if.delayed_PHT), 32'd0);
    check("bhr_shift", 32'(bp_if.delayed_BHR), 32'd6);
    tick();

    // saturation at 11
    train(32'h100, 3'd5, 2'b11, 1'b1);
    bp_if.fetch_pc = 32'h100;
    cyc();
    bp_if.fetch_pc = 32'h108;
    settle();
    check("sat11_dPHT", 32'(bp_if.delayed_PHT), 32'd3);
    check("sat11_dBHR", 32'(bp_if.delayed_BHR), 32'd5);
    tick();

    // call / return
    write_btb(32'h300, 32'h400, BTB_JAL);
    write_btb(32'h504, 32'h888, BTB_JR);
    bp_if.fetch_pc = 32'h300;
    settle();
    check("jal_pred_pc", bp_if.pred_pc, 32'h400);
    tick();
    bp_if.fetch_pc = 32'h504;
    settle();
`ifdef CORE_BP_RAS_EN
    check("jr_ras_pc", bp_if.pred_pc, 32'h304);
`else
    check("jr_btb_pc", bp_if.pred_pc, 32'h888);
`endif
    tick();
    $display("call/return done");

`ifdef CORE_BP_RAS_EN
    // repair a wrong pop, then the next return sees the restored address
    bp_if.fetch_pc = 32'h108;
    bp_if.recover_push = 1;
    bp_if.recover_push_addr = 32'h304;
    cyc();
    idle_inputs();
    bp_if.fetch_pc = 32'h504;
    settle();
    check("recover_jr_pc", bp_if.pred_pc, 32'h304);
    tick();

    // five pushes into a four-deep stack: newest four come back, oldest is gone
    for (int k = 0; k < 5; k++) begin
      bp_if.fetch_pc = 32'h108;
      bp_if.recover_push = 1;
      bp_if.recover_push_addr = 32'hA00 + 32'(4 * k);
      cyc();
    end
    idle_inputs();
    for (int k = 4; k >= 1; k--) begin
      bp_if.fetch_pc = 32'h504;
      settle();
      check("ras_overflow_pop", bp_if.pred_pc, 32'hA00 + 32'(4 * k));
      tick();
    end
    $display("ras overflow done");
`endif

    // stall holds the aligned info, flush wins over stall
    bp_if.fetch_pc = 32'h504;
    cyc();
    bp_if.stall = 1;
    bp_if.fetch_pc = 32'h108;
    settle();
    check("stall_btb_v", 32'(bp_if.btb_v), 32'd1);
    tick();
    bp_if.fetch_pc = 32'h300;
    settle();
    check("stall_hold_v", 32'(bp_if.btb_v), 32'd1);
    check("stall_hold_type", 32'(bp_if.btb_type), 32'(BTB_JR));
    tick();
    bp_if.flush = 1;
    cyc();
    idle_inputs();
    bp_if.fetch_pc = 32'h504;
    settle();
    check("flush_btb_v", 32'(bp_if.btb_v), 32'd0);
    tick();
    $display("stall/flush done");

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int pick;
      pick = int'($urandom_range(0, 15));
      bp_if.fetch_pc = 32'h100 + 32'(4 * (pick % 8)) + ((pick >= 8) ? 32'h40 : 32'h0);
      bp_if.stall = ($urandom % 5) == 0;
      bp_if.flush = ($urandom % 10) == 0;
      pick = int'($urandom_range(0, 15));
      pc_set = 32'h100 + 32'(4 * (pick % 8)) + ((pick >= 8) ? 32'h40 : 32'h0);
      bp_if.id_plus_4 = pc_set + 32'd4;
      bp_if.update_btb_target_in = ($urandom % 3) == 0;
      bp_if.btb_target_in = $urandom & 32'hFFFF_FFFC;
      bp_if.btb_type_in = 2'($urandom % 4);
      bp_if.update_BP_in = 1'($urandom % 2);
      bp_if.taken_in = 1'($urandom % 2);
      bp_if.delayed_PHT_in = 2'($urandom % 4);
      bp_if.delayed_BHR_in = 3'($urandom % 8);
      bp_if.recover_push = ($urandom % 8) == 0;
      bp_if.recover_push_addr = $urandom & 32'hFFFF_FFFC;
      bp_if.recover_pop = ($urandom % 8) == 0;
      cyc();
    end
    idle_inputs();
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
